timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter HOUR_MAX, default 99, the maximum hour value (1..255).
REQ-003 SHALL have parameter PRESET_MIN, default 1, the minutes loaded on entry to countdown (0..59).
REQ-004 SHALL have port clk_100Hz  input  1  100 Hz timing clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sel  input  CH_W  channel addressed by command pulses; CH_W = max(1, clog2(N_CH)).
REQ-007 SHALL have ports start, stop, clear, lap, min_inc, hour_inc  input  1 each  single-cycle command pulses applied to channel sel.
REQ-008 SHALL have port down_mode  input  N_CH  per-channel countdown enable (level, already debounced).
REQ-009 SHALL have port rd_sel  input  CH_W  channel driven onto the display outputs.
REQ-010 SHALL have port show_lap  input  1  1 = display lap snapshot, 0 = live value.
REQ-011 SHALL have ports hours, minutes, seconds, centisec  output  8 each  selected channel's time.
REQ-012 SHALL have port lap_valid  output  1  lap snapshot of channel rd_sel is valid.
REQ-013 SHALL have port running  output  N_CH  channel is in RUNNING.
REQ-014 SHALL have port done  output  N_CH  one-cycle pulse when a countdown reaches zero.

Function
REQ-015 Each channel SHALL run an FSM with states IDLE, RUNNING, STOPPED; start: IDLE/STOPPED -> RUNNING; stop: RUNNING -> STOPPED.
REQ-016 Command priority on one channel in one cycle SHALL be clear > stop > start > lap; the lower-priority commands are dropped.
REQ-017 clear SHALL zero the time and lap registers, drop lap_valid and enter IDLE; in countdown it loads 0:PRESET_MIN:00:00 instead of zero.
REQ-018 Count-up SHALL add one centisecond per cycle in RUNNING; fields wrap at 99/59/59/HOUR_MAX, and HOUR_MAX:59:59:99 wraps to 0:00:00:00 while staying RUNNING.
REQ-019 Count-down SHALL subtract one centisecond per cycle with borrow (centisec 0 -> 99, seconds 0 -> 59, minutes 0 -> 59).
REQ-020 On the edge that loads 0:00:00:00 in countdown, the channel SHALL enter STOPPED and assert done[ch] for exactly that one following cycle.
REQ-021 start on a countdown channel holding all-zero SHALL be ignored; the channel stays in its state and no done pulse is generated.
REQ-022 A down_mode[ch] rising edge SHALL load 0:PRESET_MIN:00:00, clear the lap, and force IDLE.
REQ-023 A down_mode[ch] falling edge SHALL load zero, clear the lap, and force IDLE; a mode edge overrides every command that cycle.
REQ-024 min_inc/hour_inc SHALL act only on a countdown channel not in RUNNING: minutes 59 -> 0, hours HOUR_MAX -> 0, with no carry between fields; otherwise they are ignored.
REQ-025 min_inc and hour_inc in the same cycle SHALL both apply.
REQ-026 lap in RUNNING SHALL copy the current pre-update live value into the lap register and set lap_valid; lap in other states is ignored.
REQ-027 Display outputs SHALL be a combinational mux of registered channel state, with zero-cycle latency from rd_sel/show_lap.
REQ-028 With show_lap=1 and lap invalid, the display SHALL show zero.
REQ-029 sel or rd_sel values >= N_CH SHALL be ignored (commands) or read as zero (display).
REQ-030 Channels not addressed by sel SHALL be unaffected by command pulses.

Reset
REQ-031 rst_n low SHALL immediately set all channels to IDLE, all time and lap fields to 0, and lap_valid, running and done to 0, independent of down_mode.
REQ-032 The per-channel down_mode history register SHALL reset to 0, so a channel released from reset with down_mode=1 loads the preset on the first clock.
REQ-033 Reset asserted mid-count SHALL discard the count; no done pulse is produced.

Structure
REQ-034 Package timer_pkg SHALL hold the FSM state enum, the field limits (CS_MAX=99, SEC_MAX=59, MIN_MAX=59) and the CH_W width function.
REQ-035 One sub-module timer_channel (FSM, counters, lap register, mode-edge detect) SHALL be instantiated N_CH times; timer_bank holds command decode and the display mux.

Verification
REQ-036 Up-count: start ch0, run 6000 cycles -> display 0:01:00:00, running[0]=1.
REQ-037 Countdown: down_mode[1]=1, start, 6000 cycles -> 0:00:00:00, done[1] high one cycle, STOPPED; a further start is ignored.
REQ-038 Wrap: HOUR_MAX=1, up-count from 1:59:59:99 -> 0:00:00:00 and still running.
REQ-039 Priority: clear+stop+start on one cycle while running -> IDLE, zero; lap+start same cycle -> lap not captured.
REQ-040 Lap/isolation: lap on ch2 at 0:00:05:00, commands to ch3 only -> ch2 lap shows 0:00:05:00 while live keeps counting; ch3 unaffected by ch2 commands.
REQ-041 Reset mid-countdown at 0:00:00:02 -> all outputs zero immediately, no done pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and limits for the multi-channel stopwatch/countdown timer bank.
// No logic, no latency.
// No flow control; these are compile-time definitions only.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
    } tmr_state_e;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // One channel's time value, most significant field first.
    typedef struct packed {
        logic [7:0] hours;
        logic [7:0] minutes;
        logic [7:0] seconds;
        logic [7:0] centisec;
    } tm_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Command and display bus of the timer bank.
// Commands are single-cycle pulses; display is combinational from registered state.
// No backpressure: every command pulse is accepted or dropped in the cycle it appears.
interface timer_bank_if
    import timer_pkg::*;
#(
    parameter int N_CH = 4
);
    localparam int CH_W = ch_w(N_CH);

    // command side
    logic [CH_W-1:0] sel;
    logic            start;
    logic            stop;
    logic            clear;
    logic            lap;
    logic            min_inc;
    logic            hour_inc;

    // display side
    logic [CH_W-1:0] rd_sel;
    logic            show_lap;
    logic [7:0]      hours;
    logic [7:0]      minutes;
    logic [7:0]      seconds;
    logic [7:0]      centisec;
    logic            lap_valid;

    modport master (
        output sel, start, stop, clear, lap, min_inc, hour_inc, rd_sel, show_lap,
        input  hours, minutes, seconds, centisec, lap_valid
    );

    modport slave (
        input  sel, start, stop, clear, lap, min_inc, hour_inc, rd_sel, show_lap,
        output hours, minutes, seconds, centisec, lap_valid
    );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUNNING/STOPPED FSM, up/down time counter, lap snapshot, mode-edge detect.
// Commands take effect on the next clk_100Hz edge; outputs are straight from flops.
// No backpressure: conflicting commands are resolved by fixed priority, losers are dropped.
module timer_channel
    import timer_pkg::*;
#(
    parameter int HOUR_MAX   = 99,
    parameter int PRESET_MIN = 1
) (
    input  logic clk_100Hz,
    input  logic rst_n,
    input  logic start_i,
    input  logic stop_i,
    input  logic clear_i,
    input  logic lap_i,
    input  logic min_inc_i,
    input  logic hour_inc_i,
    input  logic down_mode_i,
    output tm_t  live_o,
    output tm_t  lap_o,
    output logic lap_vld_o,
    output logic running_o,
    output logic done_o
);

    localparam logic [7:0] CS_LIM   = 8'(CS_MAX);
    localparam logic [7:0] SEC_LIM  = 8'(SEC_MAX);
    localparam logic [7:0] MIN_LIM  = 8'(MIN_MAX);
    localparam logic [7:0] HOUR_LIM = 8'(HOUR_MAX);
    localparam tm_t        PRESET_T = {8'd0, 8'(PRESET_MIN), 8'd0, 8'd0};

    tmr_state_e state_q, state_d;
    tm_t        live_q, live_d;
    tm_t        lap_q, lap_d;
    logic       lap_vld_q, lap_vld_d;
    logic       done_q, done_d;
    logic       mode_q, mode_d;

    tm_t        up_nxt;
    tm_t        down_nxt;
    logic       live_zero;
    logic       mode_edge;

    // Add one centisecond with carry; the top hour wraps back to zero.
    function automatic tm_t tick_up(input tm_t t);
        tm_t r;
        r = t;
        if (t.centisec >= CS_LIM) begin
            r.centisec = 8'd0;
            if (t.seconds >= SEC_LIM) begin
                r.seconds = 8'd0;
                if (t.minutes >= MIN_LIM) begin
                    r.minutes = 8'd0;
                    r.hours   = (t.hours >= HOUR_LIM) ? 8'd0 : t.hours + 8'd1;
                end else begin
                    r.minutes = t.minutes + 8'd1;
                end
            end else begin
                r.seconds = t.seconds + 8'd1;
            end
        end else begin
            r.centisec = t.centisec + 8'd1;
        end
        return r;
    endfunction

    // Subtract one centisecond with borrow; caller guarantees a nonzero value.
    function automatic tm_t tick_down(input tm_t t);
        tm_t r;
        r = t;
        if (t.centisec != 8'd0) begin
            r.centisec = t.centisec - 8'd1;
        end else begin
            r.centisec = CS_LIM;
            if (t.seconds != 8'd0) begin
                r.seconds = t.seconds - 8'd1;
            end else begin
                r.seconds = SEC_LIM;
                if (t.minutes != 8'd0) begin
                    r.minutes = t.minutes - 8'd1;
                end else begin
                    r.minutes = MIN_LIM;
                    r.hours   = t.hours - 8'd1;
                end
            end
        end
        return r;
    endfunction

    assign up_nxt    = tick_up(live_q);
    assign down_nxt  = tick_down(live_q);
    assign live_zero = (live_q == '0);
    assign mode_edge = down_mode_i ^ mode_q;

    // Next-state: mode edge and clear reload, else FSM with counting, lap capture and setting.
    always_comb begin
        state_d   = state_q;
        live_d    = live_q;
        lap_d     = lap_q;
        lap_vld_d = lap_vld_q;
        done_d    = 1'b0;
        mode_d    = down_mode_i;

        if (mode_edge || clear_i) begin
            // Entering/leaving countdown or clearing always reloads the base value.
            state_d   = ST_IDLE;
            live_d    = down_mode_i ? PRESET_T : '0;
            lap_d     = '0;
            lap_vld_d = 1'b0;
        end else if (state_q == ST_RUNNING) begin
            if (stop_i) begin
                state_d = ST_STOPPED;
            end else begin
                // start outranks lap, so a simultaneous start suppresses the capture.
                if (lap_i && !start_i) begin
                    lap_d     = live_q;
                    lap_vld_d = 1'b1;
                end
                if (down_mode_i) begin
                    if (live_zero) begin
                        state_d = ST_STOPPED;
                    end else begin
                        live_d = down_nxt;
                        if (down_nxt == '0) begin
                            state_d = ST_STOPPED;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    live_d = up_nxt;
                end
            end
        end else begin
            // A countdown with nothing left to count refuses to start.
            if (start_i && !stop_i && !(down_mode_i && live_zero)) begin
                state_d = ST_RUNNING;
            end
            // Manual setting of a paused countdown; fields wrap independently.
            if (down_mode_i && min_inc_i) begin
                live_d.minutes = (live_q.minutes >= MIN_LIM) ? 8'd0 : live_q.minutes + 8'd1;
            end
            if (down_mode_i && hour_inc_i) begin
                live_d.hours = (live_q.hours >= HOUR_LIM) ? 8'd0 : live_q.hours + 8'd1;
            end
        end
    end

    // Channel state registers; mode history clears so a held down_mode reloads after reset.
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            live_q    <= '0;
            lap_q     <= '0;
            lap_vld_q <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            lap_q     <= lap_d;
            lap_vld_q <= lap_vld_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
        end
    end

    assign live_o    = live_q;
    assign lap_o     = lap_q;
    assign lap_vld_o = lap_vld_q;
    assign running_o = (state_q == ST_RUNNING);
    assign done_o    = done_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent timer channels with command decode and a display read mux.
// Commands act on the next clk_100Hz edge; display has zero-cycle latency from rd_sel/show_lap.
// No backpressure: out-of-range selects drop commands and read back as zero.
module timer_bank
    import timer_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int HOUR_MAX   = 99,
    parameter int PRESET_MIN = 1
) (
    input  logic            clk_100Hz,
    input  logic            rst_n,
    timer_bank_if.slave     bus,
    input  logic [N_CH-1:0] down_mode,
    output logic [N_CH-1:0] running,
    output logic [N_CH-1:0] done
);

    localparam int CH_W = ch_w(N_CH);

    tm_t             live [N_CH];
    tm_t             lap  [N_CH];
    logic [N_CH-1:0] lap_vld;
    tm_t             disp;
    logic            disp_lap_vld;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // A select beyond the last channel matches no channel, so its pulses vanish.
        logic hit;
        assign hit = (bus.sel == CH_W'(i));

        timer_channel #(
            .HOUR_MAX   (HOUR_MAX),
            .PRESET_MIN (PRESET_MIN)
        ) u_ch (
            .clk_100Hz   (clk_100Hz),
            .rst_n       (rst_n),
            .start_i     (bus.start    & hit),
            .stop_i      (bus.stop     & hit),
            .clear_i     (bus.clear    & hit),
            .lap_i       (bus.lap      & hit),
            .min_inc_i   (bus.min_inc  & hit),
            .hour_inc_i  (bus.hour_inc & hit),
            .down_mode_i (down_mode[i]),
            .live_o      (live[i]),
            .lap_o       (lap[i]),
            .lap_vld_o   (lap_vld[i]),
            .running_o   (running[i]),
            .done_o      (done[i])
        );
    end

    // Display mux: live or lap of rd_sel; invalid lap and unknown channels read zero.
    always_comb begin
        disp         = '0;
        disp_lap_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_sel == CH_W'(i)) begin
                disp_lap_vld = lap_vld[i];
                if (bus.show_lap) begin
                    disp = lap_vld[i] ? lap[i] : '0;
                end else begin
                    disp = live[i];
                end
            end
        end
    end

    assign bus.hours     = disp.hours;
    assign bus.minutes   = disp.minutes;
    assign bus.seconds   = disp.seconds;
    assign bus.centisec  = disp.centisec;
    assign bus.lap_valid = disp_lap_vld;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: two instances (default 4-channel, and a 3-channel HOUR_MAX=1 one).
// Expected values are queued when stimulus is applied and popped at each observation point.
// Outputs are sampled 1 time unit after the falling clock edge.
module tb_timer_bank;

    localparam logic [5:0] C_START = 6'b000001;
    localparam logic [5:0] C_STOP  = 6'b000010;
    localparam logic [5:0] C_CLEAR = 6'b000100;
    localparam logic [5:0] C_LAP   = 6'b001000;
    localparam logic [5:0] C_MIN   = 6'b010000;
    localparam logic [5:0] C_HOUR  = 6'b100000;

    logic       clk;
    logic       rst_n;
    logic [3:0] down_mode_a, running_a, done_a;
    logic [2:0] down_mode_b, running_b, done_b;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    logic [31:0] obs;
    logic        lv;

    timer_bank_if #(.N_CH(4)) bus_a ();
    timer_bank_if #(.N_CH(3)) bus_b ();

    timer_bank #(.N_CH(4), .HOUR_MAX(99), .PRESET_MIN(1)) dut_a (
        .clk_100Hz (clk),
        .rst_n     (rst_n),
        .bus       (bus_a),
        .down_mode (down_mode_a),
        .running   (running_a),
        .done      (done_a)
    );

    timer_bank #(.N_CH(3), .HOUR_MAX(1), .PRESET_MIN(0)) dut_b (
        .clk_100Hz (clk),
        .rst_n     (rst_n),
        .bus       (bus_b),
        .down_mode (down_mode_b),
        .running   (running_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] tm(input int h, input int m, input int s, input int c);
        return {8'(h), 8'(m), 8'(s), 8'(c)};
    endfunction

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] o);
        string       tag;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h required=entry", o);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    // Drive one command pulse across exactly one rising edge; entered and left at a falling edge.
    task automatic send(input bit b, input logic [1:0] ch, input logic [5:0] c);
        if (!b) begin
            bus_a.sel = ch;
            {bus_a.hour_inc, bus_a.min_inc, bus_a.lap, bus_a.clear, bus_a.stop, bus_a.start} = c;
        end else begin
            bus_b.sel = ch;
            {bus_b.hour_inc, bus_b.min_inc, bus_b.lap, bus_b.clear, bus_b.stop, bus_b.start} = c;
        end
        @(posedge clk);
        @(negedge clk);
        {bus_a.hour_inc, bus_a.min_inc, bus_a.lap, bus_a.clear, bus_a.stop, bus_a.start} = '0;
        {bus_b.hour_inc, bus_b.min_inc, bus_b.lap, bus_b.clear, bus_b.stop, bus_b.start} = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input bit b, input logic [1:0] ch, input logic show,
                      output logic [31:0] t, output logic v);
        if (!b) begin
            bus_a.rd_sel = ch; bus_a.show_lap = show;
        end else begin
            bus_b.rd_sel = ch; bus_b.show_lap = show;
        end
        #1;
        if (!b) begin
            t = {bus_a.hours, bus_a.minutes, bus_a.seconds, bus_a.centisec};
            v = bus_a.lap_valid;
        end else begin
            t = {bus_b.hours, bus_b.minutes, bus_b.seconds, bus_b.centisec};
            v = bus_b.lap_valid;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        down_mode_a = 4'b0010;
        down_mode_b = 3'b000;
        bus_a.sel = '0; bus_a.rd_sel = '0; bus_a.show_lap = 1'b0;
        bus_b.sel = '0; bus_b.rd_sel = '0; bus_b.show_lap = 1'b0;
        {bus_a.hour_inc, bus_a.min_inc, bus_a.lap, bus_a.clear, bus_a.stop, bus_a.start} = '0;
        {bus_b.hour_inc, bus_b.min_inc, bus_b.lap, bus_b.clear, bus_b.stop, bus_b.start} = '0;

        // ---- reset state, including a countdown channel held in reset ----
        #2;
        expect_v("rst_ch0", tm(0, 0, 0, 0));      rd(0, 0, 0, obs, lv); check(obs);
        expect_v("rst_ch1_down", tm(0, 0, 0, 0)); rd(0, 1, 0, obs, lv); check(obs);
        expect_v("rst_lap_valid", 32'd0);         check(32'(lv));
        expect_v("rst_running", 32'd0);           check(32'(running_a));
        expect_v("rst_done", 32'd0);              check(32'(done_a));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        expect_v("first_clk_preset", tm(0, 1, 0, 0)); rd(0, 1, 0, obs, lv); check(obs);

        // ---- up-count one minute on ch0 ----
        send(0, 0, C_START);
        tick(6000);
        expect_v("up_1min", tm(0, 1, 0, 0)); rd(0, 0, 0, obs, lv); check(obs);
        expect_v("up_running", 32'b0001);    check(32'(running_a));

        // ---- countdown on ch1 from the one-minute preset ----
        send(0, 1, C_START);
        tick(5999);
        expect_v("dn_last_cs", tm(0, 0, 0, 1)); rd(0, 1, 0, obs, lv); check(obs);
        expect_v("dn_no_early_done", 32'd0);    check(32'(done_a));
        tick(1);
        expect_v("dn_zero", tm(0, 0, 0, 0));    rd(0, 1, 0, obs, lv); check(obs);
        expect_v("dn_done_pulse", 32'b0010);    check(32'(done_a));
        expect_v("dn_stopped", 32'b0001);       check(32'(running_a));
        tick(1);
        expect_v("dn_done_one_cycle", 32'd0);   check(32'(done_a));
        send(0, 1, C_START);
        expect_v("dn_restart_ignored", 32'b0001); check(32'(running_a));
        expect_v("dn_restart_no_done", 32'd0);    check(32'(done_a));

        // ---- priority ----
        send(0, 0, C_CLEAR | C_STOP | C_START);
        expect_v("prio_clear_idle", 32'd0);       check(32'(running_a));
        expect_v("prio_clear_zero", tm(0, 0, 0, 0)); rd(0, 0, 0, obs, lv); check(obs);
        send(0, 0, C_START);
        tick(10);
        expect_v("restart_10cs", tm(0, 0, 0, 10)); rd(0, 0, 0, obs, lv); check(obs);
        send(0, 0, C_LAP | C_START);
        expect_v("lap_start_no_valid", 32'd0);     rd(0, 0, 1, obs, lv); check(32'(lv));
        expect_v("lap_invalid_shows_zero", tm(0, 0, 0, 0)); check(obs);
        expect_v("lap_start_live", tm(0, 0, 0, 11)); rd(0, 0, 0, obs, lv); check(obs);
        send(0, 0, C_STOP);
        tick(5);
        expect_v("stop_frozen", tm(0, 0, 0, 11)); rd(0, 0, 0, obs, lv); check(obs);
        expect_v("stop_running", 32'd0);          check(32'(running_a));
        send(0, 0, C_MIN);
        expect_v("min_inc_upmode_ignored", tm(0, 0, 0, 11)); rd(0, 0, 0, obs, lv); check(obs);

        // ---- lap and channel isolation ----
        send(0, 2, C_START);
        tick(500);
        expect_v("ch2_5s", tm(0, 0, 5, 0)); rd(0, 2, 0, obs, lv); check(obs);
        send(0, 2, C_LAP);
        expect_v("ch3_untouched", tm(0, 0, 0, 0)); rd(0, 3, 0, obs, lv); check(obs);
        expect_v("ch2_only_running", 32'b0100);    check(32'(running_a));
        send(0, 3, C_START);
        tick(20);
        send(0, 3, C_LAP);
        expect_v("ch2_lap_held", tm(0, 0, 5, 0));  rd(0, 2, 1, obs, lv); check(obs);
        expect_v("ch2_lap_valid", 32'd1);          check(32'(lv));
        expect_v("ch2_live", tm(0, 0, 5, 23));     rd(0, 2, 0, obs, lv); check(obs);
        expect_v("ch3_lap", tm(0, 0, 0, 20));      rd(0, 3, 1, obs, lv); check(obs);
        expect_v("ch3_live", tm(0, 0, 0, 21));     rd(0, 3, 0, obs, lv); check(obs);

        // ---- mode edges and manual setting ----
        down_mode_a[3] = 1'b1;
        send(0, 3, C_START);
        expect_v("mode_rise_preset", tm(0, 1, 0, 0)); rd(0, 3, 0, obs, lv); check(obs);
        expect_v("mode_rise_lap_clear", 32'd0);       check(32'(lv));
        expect_v("mode_rise_idle", 32'b0100);         check(32'(running_a));
        send(0, 3, C_MIN | C_HOUR);
        expect_v("min_hour_inc", tm(1, 2, 0, 0)); rd(0, 3, 0, obs, lv); check(obs);
        down_mode_a[3] = 1'b0;
        tick(1);
        expect_v("mode_fall_zero", tm(0, 0, 0, 0)); rd(0, 3, 0, obs, lv); check(obs);

        down_mode_b[1] = 1'b1;
        tick(1);
        send(1, 1, C_HOUR);
        expect_v("b_hour_inc", tm(1, 0, 0, 0)); rd(1, 1, 0, obs, lv); check(obs);
        send(1, 1, C_HOUR);
        expect_v("b_hour_wrap", tm(0, 0, 0, 0)); rd(1, 1, 0, obs, lv); check(obs);

        // ---- top-of-range wrap on the HOUR_MAX=1 bank ----
        send(1, 0, C_START);
        force dut_b.g_ch[0].u_ch.live_q = 32'h013B3B63;
        #1;
        release dut_b.g_ch[0].u_ch.live_q;
        tick(1);
        expect_v("wrap_zero", tm(0, 0, 0, 0)); rd(1, 0, 0, obs, lv); check(obs);
        expect_v("wrap_running", 32'b001);     check(32'(running_b));
        tick(1);
        expect_v("wrap_continue", tm(0, 0, 0, 1)); rd(1, 0, 0, obs, lv); check(obs);
        send(1, 3, C_START);
        expect_v("oob_sel_ignored", 32'b001);      check(32'(running_b));
        expect_v("oob_rd_zero", tm(0, 0, 0, 0));   rd(1, 3, 0, obs, lv); check(obs);
        expect_v("oob_rd_lap_valid", 32'd0);       check(32'(lv));

        // ---- reset in the middle of a countdown ----
        send(0, 1, C_CLEAR);
        send(0, 1, C_START);
        tick(5998);
        expect_v("pre_rst_2cs", tm(0, 0, 0, 2)); rd(0, 1, 0, obs, lv); check(obs);
        rst_n = 1'b0;
        expect_v("rst_mid_ch1", tm(0, 0, 0, 0)); rd(0, 1, 0, obs, lv); check(obs);
        expect_v("rst_mid_ch2", tm(0, 0, 0, 0)); rd(0, 2, 0, obs, lv); check(obs);
        expect_v("rst_mid_running", 32'd0);      check(32'(running_a));
        expect_v("rst_mid_done", 32'd0);         check(32'(done_a));
        tick(3);
        rst_n = 1'b1;
        tick(1);
        expect_v("post_rst_no_done", 32'd0);        check(32'(done_a));
        expect_v("post_rst_preset", tm(0, 1, 0, 0)); rd(0, 1, 0, obs, lv); check(obs);
        tick(2);
        expect_v("post_rst_still_no_done", 32'd0);  check(32'(done_a));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
